// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
// Response tags record which port owns each in-flight read.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int STRB_W     = DEF_DATA_W / 8;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } resp_tag_t;

endpackage

// File: rtl/resp_tag_pipe.sv
// Fixed-depth shift register of read response tags.
// Tracks reads in flight through the memory pipeline.
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  resp_tag_t tag_in,
  output resp_tag_t tag_out
);

  resp_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of one pipelined memory.
// Data wins collisions; a starvation counter forces fetch through.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             force_if;
  resp_tag_t        new_tag;
  resp_tag_t        out_tag;

  assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

  // Grants are held low while in reset even if requests are up.
  assign d_gnt   = reset & d_req & ~(if_req & force_if);
  assign if_gnt  = reset & if_req & ~d_gnt;
  assign mem_req = if_gnt | d_gnt;

  always_comb begin
    mem_addr  = if_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (1'b1)
      d_gnt: begin
        mem_addr  = d_addr;
        mem_we    = d_we;
        mem_wdata = d_wdata;
        mem_wstrb = d_we ? d_wstrb : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!if_req || if_gnt)
      starve_nxt = '0;
    else if (!force_if)
      starve_nxt = starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_nxt;
  end

  always_comb begin
    new_tag       = '0;
    new_tag.valid = mem_req & ~mem_we;
    new_tag.owner = d_gnt ? OWN_D : OWN_IF;
  end

  resp_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tags (
    .clk     (clk),
    .rst_n   (reset),
    .tag_in  (new_tag),
    .tag_out (out_tag)
  );

  assign if_rvalid = reset & out_tag.valid & (out_tag.owner == OWN_IF);
  assign d_rvalid  = reset & out_tag.valid & (out_tag.owner == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, pipelined unified memory between the CPU instruction-fetch port and the load/store data port.
- Grants one requester per cycle and tracks in-flight reads so each response is routed back to its owner.
- Data accesses have priority, with an anti-starvation counter that guarantees fetch progress.
- Sits between the CPU core and the memory model/SRAM, replacing separate instruction and data memories.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; byte strobe width is DATA_W/8
MEM_LAT, 2, fixed memory read latency in cycles (legal range 1..4)
STARVE_MAX, 4, consecutive denied cycles of a pending fetch before fetch is forced to win

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
if_req  input  1  fetch read request
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch read data valid
if_rdata  output  DATA_W  fetch read data
d_req  input  1  data request
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_wstrb  input  DATA_W/8  byte write strobes
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  load data valid
d_rdata  output  DATA_W  load data
mem_req  output  1  memory access this cycle
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wstrb  output  DATA_W/8  memory byte strobes (0 for reads)
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after a read request

Behaviour:
Reset:
- While reset=0: if_gnt, d_gnt, mem_req, mem_we, if_rvalid and d_rvalid are all 0.
- Starvation counter and response tag pipeline are cleared.
Handshake:
- A requester holds req and its address/data stable until it sees gnt=1 in the same cycle; the transfer is accepted on that edge.
- gnt is combinational from req and the current arbiter state; the memory is assumed always ready.
Arbitration, each cycle:
- Only one requester active: it is granted.
- Both active: d wins, unless starve_cnt == STARVE_MAX, in which case if wins.
- mem_* outputs are driven from the granted port. mem_req = if_gnt | d_gnt. Fetch always drives mem_we=0 and mem_wstrb=0.
Starvation counter (0..STARVE_MAX):
- Increments when if_req=1 and if_gnt=0.
- Clears when if_gnt=1 or if_req=0.
- Saturates at STARVE_MAX; it never exceeds it.
Response tag pipeline:
- Shift register of depth MEM_LAT; each entry is {valid, owner}.
- Stage 0 is loaded with valid=1 on any granted read, owner = IF or D. Writes and idle cycles load valid=0.
- At the output stage: if_rvalid = valid & owner==IF; d_rvalid = valid & owner==D.
- if_rdata and d_rdata are mem_rdata passed through combinationally.
- Read latency is exactly MEM_LAT cycles from grant to rvalid. Responses are returned in order, with one per cycle possible back-to-back.
- Writes generate no response.
Boundary conditions:
- Read-after-write to the same address is ordered by the memory's in-order pipeline; the arbiter inserts no hazard logic.
- Reset asserted mid-flight: all in-flight tags are dropped, and no rvalid appears after reset is released for requests granted before it.
- if_req and d_req may both drop in the same cycle as a grant with no side effect.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic owner_e {OWN_IF, OWN_D}
  - typedef struct packed resp_tag_t {logic valid; owner_e owner;}
  - localparam STRB_W = DATA_W/8
- One sub-module, resp_tag_pipe: parameterised MEM_LAT-deep shift register of resp_tag_t with asynchronous active-low clear.
- Arbitration and starvation logic live in mem_arbiter.

Test Plan:
1. Fetch only (MEM_LAT=2): if_req=1, if_addr=0x100 at cycle 0 → if_gnt=1, mem_req=1, mem_addr=0x100, mem_we=0 at cycle 0; if_rvalid=1, if_rdata=0x00500093 at cycle 2; d_rvalid stays 0.
2. Collision: if_req and d_req (read 0x200) both high at cycle 0 → d_gnt=1, if_gnt=0 at cycle 0. d_req drops at cycle 1 → if_gnt=1 at cycle 1. Then d_rvalid at cycle 2 and if_rvalid at cycle 3.
3. Starvation (STARVE_MAX=4): d_req reads held continuously with if_req held → d_gnt at cycles 0–3, if_gnt at cycle 4, d_gnt again at cycle 5, starve_cnt=0 after cycle 4.
4. Write: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0xF → mem_we=1, mem_wstrb=0xF at the grant cycle, no d_rvalid. A following read of 0x200 → d_rvalid 2 cycles later with d_rdata=0xDEADBEEF.
5. Reset mid-flight: fetch read granted at cycle 0, reset=0 during cycle 1, released at cycle 3 → if_rvalid never asserts; all outputs 0 during reset.
6. Interleaved pipeline: alternating D/IF reads granted on cycles 0–5 → rvalids on cycles 2–7 alternate D/IF, each carrying mem_rdata for its own address.
